// File: rtl/mux_stim_checker.sv
// Stimulus sweep and response checker for a 2:1 select stage (z = c ? b : a).
// Optional build macro: MUX_STIM_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module mux_stim_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       vec_idx
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       vec_nx;
  logic [ERR_W-1:0] err_nx, err_inc;
  logic             done_nx, pass_nx, busy_nx;
  logic             exp_z, mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_idx <= '0;
      err_cnt <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      busy    <= 1'b0;
      a       <= 1'b0;
      b       <= 1'b0;
      c       <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      vec_idx <= vec_nx;
      err_cnt <= err_nx;
      done    <= done_nx;
      pass    <= pass_nx;
      busy    <= busy_nx;
      a       <= vec_nx[2];
      b       <= vec_nx[1];
      c       <= vec_nx[0];
    end
  end

  // Case inequality so an undriven or X response on z is scored as a failure.
  always_comb begin
    exp_z    = vec_idx[0] ? vec_idx[1] : vec_idx[2];
    mismatch = (z !== exp_z);
    err_inc  = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vec_nx   = vec_idx;
    err_nx   = err_cnt;
    done_nx  = done;
    pass_nx  = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = SETTLE;
          cnt_nx   = CNT_LOAD;
          vec_nx   = '0;
          err_nx   = '0;
          done_nx  = 1'b0;
          pass_nx  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt != '0) cnt_nx = cnt - 1'b1;
        else           state_nx = CHECK;
      end
      CHECK: begin
        if (mismatch) err_nx = err_inc;
`ifdef MUX_STIM_STOP_ON_FAIL_EN
        if (mismatch || vec_idx == 3'd7) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          pass_nx  = !mismatch;
        end else begin
          state_nx = SETTLE;
          vec_nx   = vec_idx + 3'd1;
          cnt_nx   = CNT_LOAD;
        end
`else
        if (vec_idx == 3'd7) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          pass_nx  = (err_nx == '0);
        end else begin
          state_nx = SETTLE;
          vec_nx   = vec_idx + 3'd1;
          cnt_nx   = CNT_LOAD;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == SETTLE) || (state_nx == CHECK);
  end

endmodule

// File: tb/tb_mux_stim_checker.sv
// Scoreboard bench for mux_stim_checker: two instances (SETTLE 1/ERR_W 4 and SETTLE 3/ERR_W 2)
// driven against a behavioural select stage with selectable fault modes.
module tb_mux_stim_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start3;
  logic a1, b1, c1, z1, busy1, done1, pass1;
  logic a3, b3, c3, z3, busy3, done3, pass3;
  logic [3:0] err1;
  logic [1:0] err3;
  logic [2:0] vec1, vec3;

  int mode = 0;
  bit sel  = 1'b0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int err;
    int pass;
    int vec;
    int lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux_stim_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .vec_idx(vec1)
  );

  mux_stim_checker #(.SETTLE_CYCLES(3), .ERR_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .c(c3), .z(z3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .vec_idx(vec3)
  );

  // Stage model: 0 correct, 1 stuck-at-0, 2 inverted, 3 undriven (X).
  function automatic logic stage_model(input int md, input logic sa, input logic sb_in, input logic sc);
    case (md)
      0:       return sc ? sb_in : sa;
      1:       return 1'b0;
      2:       return ~(sc ? sb_in : sa);
      default: return 1'bx;
    endcase
  endfunction

  always_comb z1 = stage_model(mode, a1, b1, c1);
  always_comb z3 = stage_model(mode, a3, b3, c3);

  logic       a_o, b_o, c_o, busy_o, done_o, pass_o;
  logic [3:0] err_o;
  logic [2:0] vec_o;
  assign a_o    = sel ? a3    : a1;
  assign b_o    = sel ? b3    : b1;
  assign c_o    = sel ? c3    : c1;
  assign busy_o = sel ? busy3 : busy1;
  assign done_o = sel ? done3 : done1;
  assign pass_o = sel ? pass3 : pass1;
  assign err_o  = sel ? {2'b00, err3} : err1;
  assign vec_o  = sel ? vec3  : vec1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_sweep(input int md, input int s, input int ew);
    exp_t r;
    int   max_err;
    bit   stopped;
    logic [2:0] vv;
    logic ez, zz;
    max_err = (1 << ew) - 1;
    r.err = 0;
    r.vec = 7;
    r.lat = 8 * (s + 1);
    stopped = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (!stopped) begin
        vv = v[2:0];
        ez = vv[0] ? vv[1] : vv[2];
        zz = stage_model(md, vv[2], vv[1], vv[0]);
`ifdef MUX_STIM_STOP_ON_FAIL_EN
        if (zz !== ez) begin
          stopped = 1'b1;
          r.err = 1;
          r.vec = v;
          r.lat = (v + 1) * (s + 1);
        end
`else
        if (zz !== ez && r.err < max_err) r.err++;
`endif
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_abc"},  {29'd0, a_o, b_o, c_o}, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_pass"}, pass_o, 0);
    checkOutput({tag, "_err"},  err_o, 0);
    checkOutput({tag, "_vec"},  vec_o, 0);
  endtask

  // One sweep on the selected instance; optional re-start pulse and reset abort at given vectors.
  task automatic applyStimulus(input bit s_sel, input int md, input int restart_at, input int reset_at);
    exp_t e, got;
    int   s, ew, bound, k;
    bit   finished, restarted;
    sel  = s_sel;
    mode = md;
    s    = s_sel ? 3 : 1;
    ew   = s_sel ? 2 : 4;
    e    = model_sweep(md, s, ew);
    sb.push_back(e);
    bound = 8 * (s + 1) + 6;
    @(posedge clk); #1;
    if (s_sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    finished = 1'b0; restarted = 1'b0;
    for (k = 0; k <= bound; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
      end
      if (done_o === 1'b1) begin
        finished = 1'b1;
        break;
      end
      checkOutput("busy_sweep", busy_o, 1);
      checkOutput("vec_sweep", vec_o, k / (s + 1));
      checkOutput("abc_sweep", {29'd0, a_o, b_o, c_o}, k / (s + 1));
      if (restart_at >= 0 && !restarted && vec_o == restart_at[2:0]) begin
        restarted = 1'b1;
        if (s_sel) start3 = 1'b1; else start1 = 1'b1;
      end
      if (reset_at >= 0 && vec_o == reset_at[2:0]) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        void'(sb.pop_front());
        #2 rst_n = 1'b1;
        return;
      end
    end
    got = sb.pop_front();
    if (!finished) begin
      checkOutput("done_timeout", 0, 1);
      return;
    end
    checkOutput("latency", k, got.lat);
    checkOutput("err_cnt", err_o, got.err);
    checkOutput("pass", pass_o, got.pass);
    checkOutput("vec_final", vec_o, got.vec);
    checkOutput("abc_final", {29'd0, a_o, b_o, c_o}, got.vec);
    checkOutput("busy_done", busy_o, 0);
    @(posedge clk); #1;
    checkOutput("done_hold", done_o, 1);
    checkOutput("pass_hold", pass_o, got.pass);
  endtask

  initial begin
    rst_n  = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    sel = 1'b0; check_all_zero("reset1");
    sel = 1'b1; check_all_zero("reset3");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    applyStimulus(1'b0, 0, -1, -1);
    applyStimulus(1'b0, 1, -1, -1);
    applyStimulus(1'b1, 2, -1, -1);
    applyStimulus(1'b1, 0, -1, -1);
    applyStimulus(1'b0, 0, 2, 5);
    applyStimulus(1'b0, 0, -1, -1);
    applyStimulus(1'b0, 3, -1, -1);
    applyStimulus(1'b1, 1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
